// File: rtl/midi_tx_if.sv
// Note-event handshake and serial line bundle for the MIDI transmitter.
interface midi_tx_if;
  logic       valid;
  logic       note_on;
  logic [3:0] channel;
  logic [6:0] key;
  logic [6:0] velocity;
  logic       ready;
  logic       busy;
  logic       done;
  logic       serial;

  modport master (
    output valid, note_on, channel, key, velocity,
    input  ready, busy, done, serial
  );

  modport slave (
    input  valid, note_on, channel, key, velocity,
    output ready, busy, done, serial
  );
endinterface

// File: rtl/midi_tx.sv
// MIDI transmitter: one note event per handshake, sent as a 3-byte
// channel message (status, key, velocity) on an 8N1 serial line.
module midi_tx #(
  parameter int unsigned BIT_CYCLES = 2080
) (
  input  logic     clock,
  input  logic     reset,
  midi_tx_if.slave bus
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [23:0]     hold_q, hold_d;   // {velocity byte, key byte, status byte}
  logic [7:0]      shift_q, shift_d;
  logic            serial_q, serial_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            baud_tc;
  logic [7:0]      cur_byte;

  assign baud_tc = (baud_q == CW'(BIT_CYCLES - 1));

  // Select the byte of the held message addressed by the byte index.
  always_comb begin
    cur_byte = hold_q[7:0];
    case (byte_q)
      2'd1:    cur_byte = hold_q[15:8];
      2'd2:    cur_byte = hold_q[23:16];
      default: cur_byte = hold_q[7:0];
    endcase
  end

  // Next-state logic; serial_d is the line level of the upcoming cycle so
  // the output stays registered while changing on the state transition.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    byte_d   = byte_q;
    hold_d   = hold_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d   = '0;
        serial_d = 1'b1;
        if (bus.valid && ready_q) begin
          hold_d   = {1'b0, bus.velocity, 1'b0, bus.key,
                      3'b100, bus.note_on, bus.channel};
          byte_d   = '0;
          state_d  = START;
          serial_d = 1'b0;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (baud_tc) begin
          baud_d   = '0;
          bit_d    = '0;
          shift_d  = cur_byte;
          serial_d = cur_byte[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            bit_d    = bit_q + 3'd1;
            // Rotate rather than shift so the next bit is simply bit 1.
            shift_d  = {shift_q[0], shift_q[7:1]};
            serial_d = shift_q[1];
          end
        end
      end
      STOP: begin
        serial_d = 1'b1;
        if (baud_tc) begin
          baud_d = '0;
          if (byte_q < 2'd2) begin
            byte_d   = byte_q + 2'd1;
            serial_d = 1'b0;
            state_d  = START;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d   = '0;
        serial_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      hold_q   <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.serial = serial_q;

endmodule

// File: doc/midi_tx.md
# midi_tx

MIDI transmitter for the 65 MHz game domain: the send-side counterpart of the `midi` keyboard receiver. It accepts one note event per valid/ready handshake and serializes it as a 3-byte MIDI channel message (status, key, velocity) on a 31250-baud, 8N1 serial line. It drives the synth/loopback pin on the PMOD header, so game logic can echo or generate notes. A looped-back line fed into `midi` must reproduce the sent key index.

## Interface

Parameters:
- `BIT_CYCLES`, default 2080: clocks per serial bit (65 MHz / 31250). Must be ≥ 4; benches use 8.

Ports:
- `clock`  in  1  65 MHz system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  event request; sampled only when `ready`=1.
- `note_on`  in  1  1 = Note On (0x9n), 0 = Note Off (0x8n).
- `channel`  in  4  MIDI channel n, 0–15.
- `key`  in  7  note number, 0–127.
- `velocity`  in  7  velocity, 0–127.
- `ready`  out  1  transmitter idle, event will be accepted this cycle if `valid`.
- `busy`  out  1  frame in progress; equals ~`ready` outside reset.
- `done`  out  1  one-cycle pulse when the last stop bit of a message completes.
- `serial`  out  1  MIDI TX line; idle high, registered output.

## Operation

- Accept: `valid` & `ready` at a rising edge latches {note_on, channel, key, velocity} into a holding register. Later input changes do not affect the message in flight.
- Byte 0 = {1, 0, 0, `note_on`, `channel`}, i.e. 0x90|n or 0x80|n. Byte 1 = {0, `key`}. Byte 2 = {0, `velocity`}. Bit 7 of the data bytes is always 0. Velocity 0 with Note On is sent verbatim, with no conversion.
- No running status: every message carries its status byte.
- Each byte is framed as a start bit (0), eight data bits LSB first, and a stop bit (1): 10 bits. A message is 30 bits with no idle gap between bytes.
- FSM states:
  - IDLE: `ready`=1, `serial`=1. On accept, go to START.
  - START: `serial`=0 for BIT_CYCLES, then go to DATA with bit counter 0.
  - DATA: `serial`=shift[0] for BIT_CYCLES per bit. After bit 7, go to STOP.
  - STOP: `serial`=1 for BIT_CYCLES. At its end:
    - if byte index < 2, increment the index and go to START;
    - otherwise pulse `done` and go to IDLE.
- Baud counter counts 0..BIT_CYCLES-1, is cleared on every state entry, and advances the bit on terminal count. Width is ceil(log2(BIT_CYCLES)); it must not overflow.
- Byte index is 2 bits, 0..2, and is cleared on accept.

## Timing

- Reset values: `serial`=1, `ready`=0, `busy`=0, `done`=0, state IDLE, counters 0. `ready` rises the first cycle after `reset` deasserts.
- Accept at edge T: `serial` falls at T+1 and `ready`/`busy` change at T+1. Each bit lasts exactly BIT_CYCLES clocks.
- The last stop bit occupies cycles T+1+29·BIT_CYCLES through T+30·BIT_CYCLES. `done`=1 and `ready`=1 in cycle T+30·BIT_CYCLES+1.
- Back-to-back: if `valid` is held, the next accept occurs at the `done` cycle and its start bit begins the following cycle. This gives exactly one extra idle-high clock between messages; no other gap is allowed.
- `valid` while `ready`=0 is ignored and not queued.
- Reset mid-frame aborts the message: `serial`=1 from the next cycle, no `done`, and the holding register is discarded.
- `done` and a new accept in the same cycle are legal.

## Test plan

- BIT_CYCLES=8, reset, then `valid` for one cycle with note_on=1, ch=0, key=60, vel=100. The line decodes to 0x90, 0x3C, 0x64. `serial` falls 1 cycle after accept, each bit is 8 cycles wide, and `done` pulses once at accept+241.
- Note Off, ch=15, key=127, vel=0 → 0x8F, 0x7F, 0x00. Data-byte MSBs are 0 and the stop bits are high.
- Hold `valid`=1 with two different events (second applied after the first accept). Expect two messages separated by exactly one high clock, `done` pulsing twice, and the second message matching the second event.
- Toggle key/velocity and pulse `valid` while `busy`. The transmitted bytes are unchanged and no extra message is sent.
- Assert `reset` during byte 1, bit 3. `serial`=1 from the next cycle, no `done` follows, and `ready` returns 1 the cycle after reset releases. A fresh event then transmits correctly.
- Loopback with BIT_CYCLES=2080: `serial` drives `midi`.`serial`. Note On key=60 produces `midi` ready with key1_index=60, and the matching Note Off clears it.
